// File: rtl/counter_sequencer.sv
// Run controller for the 8-bit up-counter: load / run / pause / terminal phases with a tick prescaler.
// Optional periodic reload is built only when COUNTER_SEQUENCER_AUTO_RELOAD_EN is defined.
module counter_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] eight_bit_counter,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [WIDTH-1:0]  load_q, load_d;
    logic [WIDTH-1:0]  term_q, term_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic              reload_q, reload_d;

`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
        end
    end
`else
    logic unused_auto_reload;
    assign unused_auto_reload = auto_reload;
    assign reload_q           = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        load_d   = load_q;
        term_d   = term_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        reload_d = reload_q;

        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d  = StRun;
                        cnt_d    = load_val;
                        load_d   = load_val;
                        term_d   = term_val;
                        pre_d    = '0;
                        reload_d = auto_reload;
                    end
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPause;
                    end else if (cnt_q == term_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            // Periodic mode: restart the period on the same edge as done.
                            cnt_d = load_q;
                            pre_d = '0;
                        end else begin
                            state_d = StDone;
                        end
                    end else if (pre_q == PreMax) begin
                        pre_d  = '0;
                        cnt_d  = cnt_q + WIDTH'(1);
                        wrap_d = &cnt_q;
                    end else begin
                        pre_d = pre_q + PreW'(1);
                    end
                end
                StPause: begin
                    if (!pause) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pre_q   <= '0;
            load_q  <= '0;
            term_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            load_q  <= load_d;
            term_q  <= term_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign eight_bit_counter = cnt_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign wrap              = wrap_q;

endmodule
